branch_resolve: RTL

Registered branch/jump resolution stage for the RV32I core. It sits directly downstream of operand read and consumes source operands, PC and immediate. It evaluates the branch condition through the comparator, computes the taken/not-taken target and the link address, and flags misaligned targets. Results are held in a single valid/ready output register that feeds PC update and writeback, with a flush input and saturating branch statistics counters.

---
 rtl/rv32i_types.sv | 37 +++
 rtl/branch_resolve_if.sv | 32 +++
 rtl/cmp.sv | 30 +++
 rtl/branch_resolve.sv | 106 ++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types for the branch resolution path: condition codes,
// branch kinds and the registered result record.
package rv32i_types;

  localparam int DATA_W = 32;
  localparam int STAT_W = 16;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_funct3_t;

  typedef enum logic [1:0] {
    BK_NONE = 2'd0,
    BK_BR   = 2'd1,
    BK_JAL  = 2'd2,
    BK_JALR = 2'd3
  } branch_kind_t;

  typedef struct packed {
    logic              redirect;
    logic [DATA_W-1:0] target;
    logic [DATA_W-1:0] link;
    logic              misaligned;
    logic              illegal;
  } br_result_t;

  // 010 and 011 are the two unassigned branch condition encodings
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Upstream (operand read) and downstream (PC update / writeback) handshake
// bundle of the branch resolution stage.
interface branch_resolve_if;
  import rv32i_types::*;

  logic              in_valid;
  logic              in_ready;
  branch_kind_t      in_kind;
  logic [2:0]        in_funct3;
  logic [DATA_W-1:0] in_pc;
  logic [DATA_W-1:0] in_rs1;
  logic [DATA_W-1:0] in_rs2;
  logic [DATA_W-1:0] in_imm;
  logic              out_valid;
  logic              out_ready;
  logic              out_redirect;
  logic [DATA_W-1:0] out_target;
  logic [DATA_W-1:0] out_link;
  logic              out_misaligned;
  logic              out_illegal;

  modport slave (
    input  in_valid, in_kind, in_funct3, in_pc, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_redirect, out_target, out_link, out_misaligned, out_illegal
  );

  modport master (
    output in_valid, in_kind, in_funct3, in_pc, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_redirect, out_target, out_link, out_misaligned, out_illegal
  );

endinterface

// File: rtl/cmp.sv
// Branch comparator: evaluates an RV32I branch condition on two operands.
module cmp
  import rv32i_types::*;
(
  input  branch_funct3_t    cmpop,
  input  logic [DATA_W-1:0] rs1_out,
  input  logic [DATA_W-1:0] cmpmux_out,
  output logic              br_en
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;

  assign a_s = rs1_out;
  assign b_s = cmpmux_out;

  always_comb begin
    br_en = 1'b0;
    case (cmpop)
      F3_BEQ:  br_en = (rs1_out == cmpmux_out);
      F3_BNE:  br_en = (rs1_out != cmpmux_out);
      F3_BLT:  br_en = (a_s < b_s);
      F3_BGE:  br_en = (a_s >= b_s);
      F3_BLTU: br_en = (rs1_out < cmpmux_out);
      F3_BGEU: br_en = (rs1_out >= cmpmux_out);
      default: br_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Registered branch/jump resolution stage: condition, target, link and
// misalignment into a one-entry valid/ready result register plus statistics.
module branch_resolve
  import rv32i_types::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  branch_resolve_if.slave    bus,
  output logic [STAT_W-1:0]  stat_br,
  output logic [STAT_W-1:0]  stat_taken
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t            state_p1, state_nxt;
  br_result_t        res_p0, res_p1;
  branch_funct3_t    cmpop_p0;
  logic              is_br_p0, illegal_p0, cmp_en_p0, cond_p0;
  logic              taken_p0, misal_p0, accept_p0, vld_p1;
  logic [DATA_W-1:0] link_p0, raw_target_p0;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage p0: combinational resolution of the offered instruction
  assign is_br_p0   = (bus.in_kind == BK_BR);
  assign illegal_p0 = is_br_p0 & f3_illegal(bus.in_funct3);
  // Non-branches and illegal encodings feed a harmless beq to the comparator
  assign cmpop_p0   = (is_br_p0 && !illegal_p0) ? branch_funct3_t'(bus.in_funct3) : F3_BEQ;

  cmp u_cmp (
    .cmpop      (cmpop_p0),
    .rs1_out    (bus.in_rs1),
    .cmpmux_out (bus.in_rs2),
    .br_en      (cmp_en_p0)
  );

  assign cond_p0       = is_br_p0 & ~illegal_p0 & cmp_en_p0;
  assign link_p0       = bus.in_pc + 32'd4;
  assign raw_target_p0 = (bus.in_kind == BK_JALR) ? ((bus.in_rs1 + bus.in_imm) & ~32'd1)
                                                  : (bus.in_pc + bus.in_imm);
  assign taken_p0      = cond_p0 | (bus.in_kind == BK_JAL) | (bus.in_kind == BK_JALR);
  assign misal_p0      = taken_p0 & (|raw_target_p0[1:0]);

  always_comb begin
    res_p0.redirect   = taken_p0 & ~misal_p0;
    res_p0.target     = (taken_p0 & ~misal_p0) ? raw_target_p0 : link_p0;
    res_p0.link       = link_p0;
    res_p0.misaligned = misal_p0;
    res_p0.illegal    = illegal_p0;
  end

  assign vld_p1       = (state_p1 == ST_FULL);
  assign bus.in_ready = ~vld_p1 | bus.out_ready;
  assign accept_p0    = bus.in_valid & bus.in_ready & ~flush;

  always_comb begin
    state_nxt = state_p1;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state_p1)
        ST_EMPTY: if (accept_p0) state_nxt = ST_FULL;
        ST_FULL:  if (!accept_p0 && bus.out_ready) state_nxt = ST_EMPTY;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Stage p1: result register and statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p1 <= ST_EMPTY;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_p1 <= '0;
    end else if (accept_p0) begin
      res_p1 <= res_p0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_br    <= '0;
      stat_taken <= '0;
    end else begin
      if (accept_p0 && is_br_p0) stat_br    <= sat_inc(stat_br);
      if (accept_p0 && cond_p0)  stat_taken <= sat_inc(stat_taken);
    end
  end

  assign bus.out_valid      = vld_p1;
  assign bus.out_redirect   = res_p1.redirect;
  assign bus.out_target     = res_p1.target;
  assign bus.out_link       = res_p1.link;
  assign bus.out_misaligned = res_p1.misaligned;
  assign bus.out_illegal    = res_p1.illegal;

endmodule
